// File: rtl/vp_pkg.sv
// Shared types and constants for the VP encoder / MAC datapath.
package vp_pkg;

    localparam int VP_GROUP = 3;
    localparam int DATA_W   = 16;
    localparam int PROD_W   = 2 * DATA_W;

    typedef logic [2:0][6:0]            ADDR_T;
    typedef logic signed [DATA_W-1:0]   DATA_T;
    typedef logic signed [PROD_W-1:0]   PROD_T;

    typedef enum logic [1:0] {
        S_ACC,
        S_WAIT,
        S_DRAIN
    } VP_STATE_T;

    // Full-precision signed 16x16 product; -32768 * -32768 = 2^30 still fits in 32 bits.
    function automatic PROD_T mulS16(input DATA_T a, input DATA_T b);
        return PROD_T'(a) * PROD_T'(b);
    endfunction

endpackage

// File: rtl/vp_mul3.sv
// Registered three-lane signed 16x16 -> 32 multiplier; carries the channel tags alongside.
module vp_mul3
    import vp_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_valid,
    input  DATA_T [VP_GROUP-1:0]             i_w,
    input  DATA_T [VP_GROUP-1:0]             i_ia,
    input  logic  [VP_GROUP-1:0][CH_W-1:0]   i_oc,
    output logic                             o_valid,
    output PROD_T [VP_GROUP-1:0]             o_prod,
    output logic  [VP_GROUP-1:0][CH_W-1:0]   o_oc
);

    // Product register: only reloads when a group is presented so idle cycles keep old data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_prod  <= '0;
            o_oc    <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                for (int k = 0; k < VP_GROUP; k++) begin
                    o_prod[k] <= mulS16(i_w[k], i_ia[k]);
                end
                o_oc <= i_oc;
            end
        end
    end

endmodule

// File: rtl/vp_mac_accumulator.sv
// Consumes the encoder's ping-pong buffers, multiplies each group and accumulates
// per output channel, then drains the bank through a valid/ready port.
module vp_mac_accumulator
    import vp_pkg::*;
#(
    parameter  int OC_NUM = 16,
    parameter  int ACC_W  = 40,
    localparam int CH_W   = $clog2(OC_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_right_ready,
    input  ADDR_T [VP_GROUP-1:0]     i_addr_right,
    input  DATA_T [VP_GROUP-1:0]     i_w_right,
    input  DATA_T [VP_GROUP-1:0]     i_ia_right,
    input  logic                     i_left_ready,
    input  ADDR_T [VP_GROUP-1:0]     i_addr_left,
    input  DATA_T [VP_GROUP-1:0]     i_w_left,
    input  DATA_T [VP_GROUP-1:0]     i_ia_left,
    input  logic                     i_enc_finish,
    output logic                     o_psum_valid,
    input  logic                     i_psum_ready,
    output logic [CH_W-1:0]          o_psum_ch,
    output logic signed [ACC_W-1:0]  o_psum_data,
    output logic                     o_done,
    output logic                     o_busy,
    output logic                     o_overrun
);

    // Two guard bits cover the accumulator plus three 32-bit products without overflow.
    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef logic [VP_GROUP-1:0][CH_W-1:0] OC_VEC_T;

    VP_STATE_T              state_q, state_d;

    logic                   rightPrev_q, leftPrev_q, finishPrev_q;
    logic                   rightRise, leftRise, finishRise;

    logic                   pendValid_q, pendValid_d;
    DATA_T [VP_GROUP-1:0]   pendW_q, pendW_d;
    DATA_T [VP_GROUP-1:0]   pendIa_q, pendIa_d;
    OC_VEC_T                pendOc_q, pendOc_d;

    logic                   s1Valid_q, s1Valid_d;
    DATA_T [VP_GROUP-1:0]   s1W_q, s1W_d;
    DATA_T [VP_GROUP-1:0]   s1Ia_q, s1Ia_d;
    OC_VEC_T                s1Oc_q, s1Oc_d;

    logic                   s2Valid;
    PROD_T [VP_GROUP-1:0]   s2Prod;
    OC_VEC_T                s2Oc;

    logic signed [ACC_W-1:0] acc_q [OC_NUM];
    logic signed [ACC_W-1:0] acc_d [OC_NUM];

    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   clearAcc;
    logic                   acceptEdges;

    OC_VEC_T                rightOc, leftOc;
    logic                   unusedAddrBits;

    assign rightRise  = i_right_ready & ~rightPrev_q;
    assign leftRise   = i_left_ready  & ~leftPrev_q;
    assign finishRise = i_enc_finish  & ~finishPrev_q;

    // Row/column and the high channel bits are not needed by the accumulator.
    assign unusedAddrBits = ^{i_addr_right, i_addr_left};

    // Clamp a widened sum into the signed accumulator range.
    function automatic logic signed [ACC_W-1:0] satAcc(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(ACC_MAX)) begin
            return ACC_MAX;
        end else if (v < SUM_W'(ACC_MIN)) begin
            return ACC_MIN;
        end
        return ACC_W'(v);
    endfunction

    // Add every lane whose channel tag matches this accumulator, then saturate once.
    function automatic logic signed [ACC_W-1:0] nextAcc(
        input logic signed [ACC_W-1:0] acc,
        input PROD_T [VP_GROUP-1:0]    prods,
        input OC_VEC_T                 ocs,
        input logic [CH_W-1:0]         ch
    );
        logic signed [SUM_W-1:0] sum;
        sum = SUM_W'(acc);
        for (int k = 0; k < VP_GROUP; k++) begin
            if (ocs[k] == ch) begin
                sum = sum + SUM_W'($signed(prods[k]));
            end
        end
        return satAcc(sum);
    endfunction

    // Channel index is the low bits of the oc element of each entry's address.
    always_comb begin
        rightOc = '0;
        leftOc  = '0;
        for (int k = 0; k < VP_GROUP; k++) begin
            rightOc[k] = i_addr_right[k][2][CH_W-1:0];
            leftOc[k]  = i_addr_left[k][2][CH_W-1:0];
        end
    end

    // Choose what enters stage 1: right edge first, then a parked left group, then a lone left edge.
    always_comb begin
        acceptEdges = (state_q == S_ACC);
        s1Valid_d   = 1'b0;
        s1W_d       = s1W_q;
        s1Ia_d      = s1Ia_q;
        s1Oc_d      = s1Oc_q;
        pendValid_d = pendValid_q;
        pendW_d     = pendW_q;
        pendIa_d    = pendIa_q;
        pendOc_d    = pendOc_q;
        overrun_d   = overrun_q;

        if (acceptEdges && rightRise) begin
            s1Valid_d = 1'b1;
            s1W_d     = i_w_right;
            s1Ia_d    = i_ia_right;
            s1Oc_d    = rightOc;
            if (leftRise) begin
                if (pendValid_q) begin
                    overrun_d = 1'b1;
                end else begin
                    pendValid_d = 1'b1;
                    pendW_d     = i_w_left;
                    pendIa_d    = i_ia_left;
                    pendOc_d    = leftOc;
                end
            end
        end else if (pendValid_q) begin
            s1Valid_d   = 1'b1;
            s1W_d       = pendW_q;
            s1Ia_d      = pendIa_q;
            s1Oc_d      = pendOc_q;
            pendValid_d = 1'b0;
            if (acceptEdges && leftRise) begin
                pendValid_d = 1'b1;
                pendW_d     = i_w_left;
                pendIa_d    = i_ia_left;
                pendOc_d    = leftOc;
            end
        end else if (acceptEdges && leftRise) begin
            s1Valid_d = 1'b1;
            s1W_d     = i_w_left;
            s1Ia_d    = i_ia_left;
            s1Oc_d    = leftOc;
        end

        if (!acceptEdges && (rightRise || leftRise)) begin
            overrun_d = 1'b1;
        end
    end

    // Control FSM: accumulate, let the pipeline empty, then stream out every channel.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        done_d   = 1'b0;
        clearAcc = 1'b0;
        unique case (state_q)
            S_ACC: begin
                if (finishRise) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!s1Valid_q && !s2Valid && !pendValid_q) begin
                    state_d = S_DRAIN;
                    ch_d    = '0;
                end
            end
            S_DRAIN: begin
                if (i_psum_ready) begin
                    if (ch_q == CH_W'(OC_NUM - 1)) begin
                        ch_d     = '0;
                        done_d   = 1'b1;
                        clearAcc = 1'b1;
                        state_d  = S_ACC;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // Accumulator next values: clearing after the last drained result wins over any update.
    always_comb begin
        for (int c = 0; c < OC_NUM; c++) begin
            acc_d[c] = acc_q[c];
            if (clearAcc) begin
                acc_d[c] = '0;
            end else if (s2Valid) begin
                acc_d[c] = nextAcc(acc_q[c], s2Prod, s2Oc, CH_W'(c));
            end
        end
    end

    // Drain port and status are decoded from the current state only.
    always_comb begin
        o_psum_valid = (state_q == S_DRAIN);
        o_psum_ch    = '0;
        o_psum_data  = '0;
        if (state_q == S_DRAIN) begin
            o_psum_ch   = ch_q;
            o_psum_data = acc_q[ch_q];
        end
        o_busy = (state_q != S_ACC) || s1Valid_q || s2Valid || pendValid_q;
    end

    assign o_done    = done_q;
    assign o_overrun = overrun_q;

    // All state registers; reset discards partial sums and any in-flight groups at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_ACC;
            rightPrev_q  <= 1'b0;
            leftPrev_q   <= 1'b0;
            finishPrev_q <= 1'b0;
            pendValid_q  <= 1'b0;
            pendW_q      <= '0;
            pendIa_q     <= '0;
            pendOc_q     <= '0;
            s1Valid_q    <= 1'b0;
            s1W_q        <= '0;
            s1Ia_q       <= '0;
            s1Oc_q       <= '0;
            ch_q         <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int c = 0; c < OC_NUM; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rightPrev_q  <= i_right_ready;
            leftPrev_q   <= i_left_ready;
            finishPrev_q <= i_enc_finish;
            pendValid_q  <= pendValid_d;
            pendW_q      <= pendW_d;
            pendIa_q     <= pendIa_d;
            pendOc_q     <= pendOc_d;
            s1Valid_q    <= s1Valid_d;
            s1W_q        <= s1W_d;
            s1Ia_q       <= s1Ia_d;
            s1Oc_q       <= s1Oc_d;
            ch_q         <= ch_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            for (int c = 0; c < OC_NUM; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    vp_mul3 #(
        .CH_W (CH_W)
    ) u_mul3 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (s1Valid_q),
        .i_w     (s1W_q),
        .i_ia    (s1Ia_q),
        .i_oc    (s1Oc_q),
        .o_valid (s2Valid),
        .o_prod  (s2Prod),
        .o_oc    (s2Oc)
    );

endmodule

// File: tb/tb_vp_mac_accumulator.sv
// Directed + randomized bench for vp_mac_accumulator with a per-channel arithmetic model.
module tb_vp_mac_accumulator;
    import vp_pkg::*;

    localparam int OC_NUM = 16;
    localparam int ACC_W  = 34;
    localparam int CH_W   = $clog2(OC_NUM);
    localparam longint SAT_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    rstN = 1'b0;
    logic                    rightReady = 1'b0;
    ADDR_T [2:0]             addrRight = '0;
    DATA_T [2:0]             wRight = '0;
    DATA_T [2:0]             iaRight = '0;
    logic                    leftReady = 1'b0;
    ADDR_T [2:0]             addrLeft = '0;
    DATA_T [2:0]             wLeft = '0;
    DATA_T [2:0]             iaLeft = '0;
    logic                    encFinish = 1'b0;
    logic                    psumValid;
    logic                    psumReady = 1'b0;
    logic [CH_W-1:0]         psumCh;
    logic signed [ACC_W-1:0] psumData;
    logic                    done;
    logic                    busy;
    logic                    overrun;

    int     totalCount = 0;
    int     badCount   = 0;
    longint modelAcc [OC_NUM];
    int     gW [3];
    int     gIa [3];
    int     gOc [3];

    always #5 clk = ~clk;

    vp_mac_accumulator #(
        .OC_NUM (OC_NUM),
        .ACC_W  (ACC_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_right_ready (rightReady),
        .i_addr_right  (addrRight),
        .i_w_right     (wRight),
        .i_ia_right    (iaRight),
        .i_left_ready  (leftReady),
        .i_addr_left   (addrLeft),
        .i_w_left      (wLeft),
        .i_ia_left     (iaLeft),
        .i_enc_finish  (encFinish),
        .o_psum_valid  (psumValid),
        .i_psum_ready  (psumReady),
        .o_psum_ch     (psumCh),
        .o_psum_data   (psumData),
        .o_done        (done),
        .o_busy        (busy),
        .o_overrun     (overrun)
    );

    // Advance n clock edges and settle just after the last one.
    task automatic stepCycle(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        totalCount++;
        assert (observed === expected) else begin
            badCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present the current gW/gIa/gOc group on one side and raise its ready.
    task automatic applyStimulus(input bit isLeft);
        for (int k = 0; k < 3; k++) begin
            if (isLeft) begin
                wLeft[k]    = DATA_T'(gW[k]);
                iaLeft[k]   = DATA_T'(gIa[k]);
                addrLeft[k] = {7'(gOc[k]), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
            end else begin
                wRight[k]    = DATA_T'(gW[k]);
                iaRight[k]   = DATA_T'(gIa[k]);
                addrRight[k] = {7'(gOc[k]), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
            end
        end
        if (isLeft) leftReady = 1'b1;
        else        rightReady = 1'b1;
    endtask

    task automatic randomGroup();
        for (int k = 0; k < 3; k++) begin
            gW[k]  = int'($urandom_range(0, 65535)) - 32768;
            gIa[k] = int'($urandom_range(0, 65535)) - 32768;
            gOc[k] = int'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) gW[k] = 0;
        end
    endtask

    // Reference: a group adds w*ia into channel (oc mod OC_NUM), then each channel clamps.
    function automatic void modelApply();
        longint delta [OC_NUM];
        longint v;
        for (int c = 0; c < OC_NUM; c++) delta[c] = 0;
        for (int k = 0; k < 3; k++) begin
            delta[gOc[k] % OC_NUM] += longint'(gW[k]) * longint'(gIa[k]);
        end
        for (int c = 0; c < OC_NUM; c++) begin
            v = modelAcc[c] + delta[c];
            if (v > SAT_MAX) v = SAT_MAX;
            if (v < SAT_MIN) v = SAT_MIN;
            modelAcc[c] = v;
        end
    endfunction

    function automatic longint peekAcc(input int c);
        return longint'($signed(dut.acc_q[c]));
    endfunction

    task automatic checkBankZero(input string tag);
        int nonZero = 0;
        for (int c = 0; c < OC_NUM; c++) begin
            if (peekAcc(c) != 0) nonZero++;
        end
        checkOutput(tag, nonZero, 0);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!psumValid && n < 30) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "-reach"}, psumValid, 1);
    endtask

    // Drain every channel with ready alternating 0/1 and compare each cycle against the model.
    task automatic drainAndCheck(input string tag);
        int got = 0;
        int guard = 0;
        int doneSeen = 0;
        bit phase = 1'b0;
        while (got < OC_NUM && guard < 100) begin
            guard++;
            psumReady = phase;
            phase = ~phase;
            checkOutput({tag, "-valid"}, psumValid, 1);
            checkOutput({tag, "-ch"}, psumCh, got);
            checkOutput({tag, "-data"}, psumData, modelAcc[got]);
            doneSeen += int'(done);
            if (psumValid && psumReady) got++;
            stepCycle();
        end
        psumReady = 1'b0;
        checkOutput({tag, "-count"}, got, OC_NUM);
        checkOutput({tag, "-doneEarly"}, doneSeen, 0);
        checkOutput({tag, "-done"}, done, 1);
        checkOutput({tag, "-idle"}, psumValid, 0);
        stepCycle();
        checkOutput({tag, "-donePulse"}, done, 0);
        for (int c = 0; c < OC_NUM; c++) modelAcc[c] = 0;
        checkBankZero({tag, "-cleared"});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint snapA;
        longint snapB;
        for (int c = 0; c < OC_NUM; c++) modelAcc[c] = 0;

        $display("[TB] reset");
        stepCycle(2);
        checkOutput("reset-valid", psumValid, 0);
        checkOutput("reset-ch", psumCh, 0);
        checkOutput("reset-data", psumData, 0);
        checkOutput("reset-done", done, 0);
        checkOutput("reset-busy", busy, 0);
        checkOutput("reset-overrun", overrun, 0);
        rstN = 1'b1;
        stepCycle();

        $display("[TB] single right group and latency");
        gW = '{2, -3, 4};
        gIa = '{5, 7, -1};
        gOc = '{0, 1, 0};
        applyStimulus(1'b0);
        modelApply();
        stepCycle(2);
        checkOutput("lat-early-acc0", peekAcc(0), 0);
        checkOutput("lat-busy", busy, 1);
        stepCycle();
        checkOutput("lat-acc0", peekAcc(0), 6);
        checkOutput("lat-acc1", peekAcc(1), -21);

        $display("[TB] level held then re-risen");
        stepCycle(2);
        rightReady = 1'b0;
        stepCycle();
        applyStimulus(1'b0);
        modelApply();
        stepCycle(5);
        rightReady = 1'b0;
        checkOutput("hold-acc0", peekAcc(0), modelAcc[0]);
        checkOutput("hold-acc1", peekAcc(1), modelAcc[1]);
        checkOutput("hold-acc0-const", peekAcc(0), 12);
        stepCycle();

        $display("[TB] simultaneous left and right edges");
        gW = '{1, 1, 1};
        gIa = '{1, 1, 1};
        gOc = '{3, 19, 67};
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        modelApply();
        snapA = modelAcc[3];
        modelApply();
        snapB = modelAcc[3];
        stepCycle(3);
        checkOutput("both-t3-acc3", peekAcc(3), snapA);
        stepCycle();
        checkOutput("both-t4-acc3", peekAcc(3), snapB);
        rightReady = 1'b0;
        leftReady = 1'b0;
        stepCycle(2);

        $display("[TB] randomized groups");
        for (int it = 0; it < 24; it++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            if (mode != 1) begin
                randomGroup();
                applyStimulus(1'b0);
                modelApply();
            end
            if (mode != 0) begin
                randomGroup();
                applyStimulus(1'b1);
                modelApply();
            end
            stepCycle(int'($urandom_range(1, 3)));
            rightReady = 1'b0;
            leftReady = 1'b0;
            stepCycle(int'($urandom_range(1, 2)));
        end
        stepCycle(5);
        checkOutput("rand-idle-busy", busy, 0);

        $display("[TB] finish together with a final group, then drain");
        randomGroup();
        applyStimulus(1'b0);
        modelApply();
        encFinish = 1'b1;
        stepCycle();
        rightReady = 1'b0;
        checkOutput("fin-busy", busy, 1);
        waitValid("drain1");
        drainAndCheck("drain1");
        stepCycle(3);
        checkOutput("fin-level-no-redrain", psumValid, 0);
        encFinish = 1'b0;
        stepCycle();

        $display("[TB] saturation");
        for (int pat = 0; pat < 2; pat++) begin
            for (int g = 0; g < 4; g++) begin
                gW = '{-32768, -32768, -32768};
                if (pat == 0) begin
                    gIa = '{-32768, -32768, -32768};
                    gOc = '{0, 0, 0};
                end else begin
                    gIa = '{32767, 32767, 32767};
                    gOc = '{5, 5, 5};
                end
                applyStimulus(1'b0);
                modelApply();
                stepCycle(4);
                rightReady = 1'b0;
                checkOutput("sat-acc", peekAcc(pat * 5), modelAcc[pat * 5]);
                checkOutput("sat-sign", longint'(peekAcc(pat * 5) < 0), longint'(pat));
                stepCycle();
            end
        end
        checkOutput("sat-max", peekAcc(0), SAT_MAX);
        checkOutput("sat-min", peekAcc(5), SAT_MIN);

        $display("[TB] overrun during drain");
        checkOutput("ovr-init", overrun, 0);
        encFinish = 1'b1;
        waitValid("drain2");
        randomGroup();
        gW = '{1000, 2000, 3000};
        applyStimulus(1'b0);
        stepCycle();
        rightReady = 1'b0;
        checkOutput("ovr-set", overrun, 1);
        checkOutput("ovr-ch-held", psumCh, 0);
        drainAndCheck("drain2");
        checkOutput("ovr-sticky", overrun, 1);
        encFinish = 1'b0;
        stepCycle(2);
        checkOutput("ovr-sticky-late", overrun, 1);

        $display("[TB] reset in the middle of a drain");
        gW = '{7, 0, 0};
        gIa = '{9, 0, 0};
        gOc = '{2, 2, 2};
        applyStimulus(1'b0);
        modelApply();
        stepCycle();
        rightReady = 1'b0;
        encFinish = 1'b1;
        waitValid("drain3");
        psumReady = 1'b1;
        stepCycle(3);
        psumReady = 1'b0;
        checkOutput("mid-ch", psumCh, 3);
        checkOutput("mid-data-pre", peekAcc(2), modelAcc[2]);
        rstN = 1'b0;
        encFinish = 1'b0;
        #1;
        checkOutput("rst-now-valid", psumValid, 0);
        checkOutput("rst-now-ch", psumCh, 0);
        checkOutput("rst-now-overrun", overrun, 0);
        stepCycle();
        checkOutput("rst-valid", psumValid, 0);
        checkOutput("rst-data", psumData, 0);
        checkOutput("rst-done", done, 0);
        checkOutput("rst-busy", busy, 0);
        checkOutput("rst-overrun", overrun, 0);
        checkBankZero("rst-bank");
        rstN = 1'b1;
        stepCycle(2);
        checkOutput("post-rst-valid", psumValid, 0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
